m_addr_counter: RTL

Loadable up/down address counter that consumes the three-way next-value selection used throughout the counter logic. Each cycle the block chooses among increment/decrement, a parallel load from the data bus, or a reload from a stored base register, and registers the result. It sits directly downstream of the per-bit three-input select. It provides the running address, busy/halt status and a terminal-count pulse to the sequencing logic.

---
 rtl/m_addr_counter.sv | 113 +++++++++++
 1 files changed

// File: rtl/m_addr_counter.sv
// Loadable up/down address counter with IDLE/RUN/HALT sequencing; all outputs registered, 1-cycle latency, no backpressure.
// Define COUNTER_AUTORELOAD_EN to reload BASE on terminal count instead of halting.
module m_addr_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESETL,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  input  logic             RELOAD,
  input  logic             BASE_WR,
  input  logic             START,
  input  logic             STOP,
  input  logic             EN,
  input  logic             DIR,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             HALTED,
  output logic             TC
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_base;
  logic             r_busy;
  logic             r_halted;
  logic             r_tc;

  logic             w_sel0;
  logic             w_sel1;
  logic             w_step;
  logic             w_term;
  logic [WIDTH-1:0] w_tv;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_q_nxt;
  state_t           w_state_nxt;

  assign w_sel0 = LOAD;
  assign w_sel1 = RELOAD & ~LOAD;
  assign w_step = (r_state == S_RUN) & EN & ~LOAD & ~RELOAD;
  assign w_tv   = DIR ? '0 : '1;
  assign w_term = w_step & (r_q == w_tv);

  // Count leg of the select: the terminal check suppresses the step, so counting never wraps.
  always_comb begin
    w_a = r_q;
    if (w_term) begin
`ifdef COUNTER_AUTORELOAD_EN
      w_a = r_base;
`else
      w_a = r_q;
`endif
    end else if (w_step) begin
      w_a = DIR ? (r_q - ONE) : (r_q + ONE);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_sel
    assign w_q_nxt[i] = w_sel0 ? D[i] : (w_sel1 ? r_base[i] : w_a[i]);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (STOP) begin
      w_state_nxt = S_IDLE;
    end else if (LOAD && (r_state == S_HALT)) begin
      w_state_nxt = S_IDLE;
    end else if (START && (r_state == S_IDLE)) begin
      w_state_nxt = S_RUN;
    end else if (w_term) begin
`ifdef COUNTER_AUTORELOAD_EN
      w_state_nxt = S_RUN;
`else
      w_state_nxt = S_HALT;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_base   <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_busy   <= (w_state_nxt == S_RUN);
      r_halted <= (w_state_nxt == S_HALT);
      r_tc     <= w_term;
      // Reload above reads r_base before this write lands, so same-cycle reload sees the old base.
      if (BASE_WR) begin
        r_base <= D;
      end
    end
  end

  assign Q      = r_q;
  assign BUSY   = r_busy;
  assign HALTED = r_halted;
  assign TC     = r_tc;

endmodule
